// File: rtl/core_pkg.sv
// Shared RV32 core definitions: control-word bit indices and the ID/EX payload bundle.
package core_pkg;

    localparam int unsigned CORE_XLEN       = 32;
    localparam int unsigned CORE_CTRL_WIDTH = 16;
    localparam int unsigned REG_ADDR_W      = 5;
    localparam int unsigned FUNCT_W         = 4;

    localparam int unsigned CTRL_MEM_TO_REG = 0;
    localparam int unsigned CTRL_REG_WR     = 1;
    localparam int unsigned CTRL_MEM_WE     = 2;
    localparam int unsigned CTRL_MEM_RE     = 3;
    localparam int unsigned CTRL_BRANCH     = 4;
    localparam int unsigned CTRL_ALUSRC     = 5;
    localparam int unsigned CTRL_ALUOP_LO   = 6;
    localparam int unsigned CTRL_ALUOP_HI   = 7;
    localparam int unsigned CTRL_JAL        = 8;

    typedef struct packed {
        logic [CORE_XLEN-1:0]       pc;
        logic [CORE_XLEN-1:0]       rs1_data;
        logic [CORE_XLEN-1:0]       rs2_data;
        logic [CORE_XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0]      rs1_addr;
        logic [REG_ADDR_W-1:0]      rs2_addr;
        logic [REG_ADDR_W-1:0]      rd_addr;
        logic [FUNCT_W-1:0]         funct;
        logic [CORE_CTRL_WIDTH-1:0] ctrl;
    } id_ex_bundle_t;

    localparam int unsigned ID_EX_BUNDLE_W = $bits(id_ex_bundle_t);

endpackage

// File: rtl/id_ex_stage_skid_buf.sv
// Generic 2-entry valid/ready register (main + skid) with synchronous flush.
// in_ready_op comes straight from a flop, so downstream ready never reaches upstream combinationally.
module skid_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk_ip,
    input  logic         rstn_ip,
    input  logic         flush_ip,
    input  logic         in_valid_ip,
    output logic         in_ready_op,
    input  logic [W-1:0] in_data_ip,
    output logic         out_valid_op,
    input  logic         out_ready_ip,
    output logic [W-1:0] out_data_op
);

    logic         r_main_valid;
    logic         r_skid_valid;
    logic         r_in_ready;
    logic [W-1:0] r_main_data;
    logic [W-1:0] r_skid_data;

    logic w_accept;
    logic w_fire;
    logic w_main_valid_nxt;
    logic w_skid_valid_nxt;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_accept = in_valid_ip & r_in_ready & ~flush_ip;
    assign w_fire   = r_main_valid & out_ready_ip;

    // Occupancy transitions; flush empties both entries but cannot undo a fire already seen by EX.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush_ip) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid) begin
            if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_load_main_in   = 1'b1;
            end
        end else if (!r_skid_valid) begin
            if (w_accept && w_fire) begin
                w_load_main_in   = 1'b1;
            end else if (w_accept) begin
                w_skid_valid_nxt = 1'b1;
                w_load_skid      = 1'b1;
            end else if (w_fire) begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_fire) begin
            w_skid_valid_nxt = 1'b0;
            w_load_main_skid = 1'b1;
        end
    end

    always_ff @(posedge clk_ip or negedge rstn_ip) begin
        if (!rstn_ip) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
            if (w_load_main_in) begin
                r_main_data <= in_data_ip;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data_ip;
            end
        end
    end

    assign in_ready_op  = r_in_ready;
    assign out_valid_op = r_main_valid;
    assign out_data_op  = r_main_data;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: skid-buffered decode bundle with bubble-safe control gating.
// Optional macro ID_EX_LOAD_USE_STALL_EN inserts one bubble on a load-use hazard.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int unsigned CTRL_WIDTH = CORE_CTRL_WIDTH,
    parameter int unsigned XLEN       = CORE_XLEN
) (
    input  logic                  clk_ip,
    input  logic                  rstn_ip,
    input  logic                  flush_ip,
    input  logic                  in_valid_ip,
    output logic                  in_ready_op,
    input  logic [XLEN-1:0]       pc_ip,
    input  logic [XLEN-1:0]       rs1_data_ip,
    input  logic [XLEN-1:0]       rs2_data_ip,
    input  logic [XLEN-1:0]       imm_ip,
    input  logic [4:0]            rs1_addr_ip,
    input  logic [4:0]            rs2_addr_ip,
    input  logic [4:0]            rd_addr_ip,
    input  logic [3:0]            funct_ip,
    input  logic [CTRL_WIDTH-1:0] ctrl_ip,
    output logic                  out_valid_op,
    input  logic                  out_ready_ip,
    output logic [XLEN-1:0]       pc_op,
    output logic [XLEN-1:0]       rs1_data_op,
    output logic [XLEN-1:0]       rs2_data_op,
    output logic [XLEN-1:0]       imm_op,
    output logic [4:0]            rs1_addr_op,
    output logic [4:0]            rs2_addr_op,
    output logic [4:0]            rd_addr_op,
    output logic [3:0]            funct_op,
    output logic [CTRL_WIDTH-1:0] ctrl_op
);

    id_ex_bundle_t w_in;
    id_ex_bundle_t w_out;
    logic          w_buf_ready;
    logic          w_out_valid;
    logic          w_stall;

    always_comb begin
        w_in          = '0;
        w_in.pc       = CORE_XLEN'(pc_ip);
        w_in.rs1_data = CORE_XLEN'(rs1_data_ip);
        w_in.rs2_data = CORE_XLEN'(rs2_data_ip);
        w_in.imm      = CORE_XLEN'(imm_ip);
        w_in.rs1_addr = rs1_addr_ip;
        w_in.rs2_addr = rs2_addr_ip;
        w_in.rd_addr  = rd_addr_ip;
        w_in.funct    = funct_ip;
        w_in.ctrl     = CORE_CTRL_WIDTH'(ctrl_ip);
    end

    skid_buf #(
        .W (ID_EX_BUNDLE_W)
    ) u_skid_buf (
        .clk_ip       (clk_ip),
        .rstn_ip      (rstn_ip),
        .flush_ip     (flush_ip),
        .in_valid_ip  (in_valid_ip & ~w_stall),
        .in_ready_op  (w_buf_ready),
        .in_data_ip   (w_in),
        .out_valid_op (w_out_valid),
        .out_ready_ip (out_ready_ip),
        .out_data_op  (w_out)
    );

`ifdef ID_EX_LOAD_USE_STALL_EN
    logic       r_ld_pending;
    logic [4:0] r_ld_rd;
    logic       w_fire;

    assign w_fire  = w_out_valid & out_ready_ip;
    assign w_stall = r_ld_pending & in_valid_ip &
                     ((rs1_addr_ip == r_ld_rd) | (rs2_addr_ip == r_ld_rd));

    // The hazard also retires once its bubble has been inserted, so a drained pipe cannot deadlock.
    always_ff @(posedge clk_ip or negedge rstn_ip) begin
        if (!rstn_ip) begin
            r_ld_pending <= 1'b0;
            r_ld_rd      <= '0;
        end else if (flush_ip) begin
            r_ld_pending <= 1'b0;
        end else if (w_fire) begin
            r_ld_pending <= w_out.ctrl[CTRL_MEM_RE] & (w_out.rd_addr != 5'd0);
            r_ld_rd      <= w_out.rd_addr;
        end else if (w_stall) begin
            r_ld_pending <= 1'b0;
        end
    end
`else
    assign w_stall = 1'b0;
`endif

    assign in_ready_op  = w_buf_ready & ~w_stall;
    assign out_valid_op = w_out_valid;
    assign pc_op        = XLEN'(w_out.pc);
    assign rs1_data_op  = XLEN'(w_out.rs1_data);
    assign rs2_data_op  = XLEN'(w_out.rs2_data);
    assign imm_op       = XLEN'(w_out.imm);
    assign rs1_addr_op  = w_out.rs1_addr;
    assign rs2_addr_op  = w_out.rs2_addr;
    assign rd_addr_op   = w_out.rd_addr;
    assign funct_op     = w_out.funct;
    // Bubbles never carry write enables into EX.
    assign ctrl_op      = w_out_valid ? CTRL_WIDTH'(w_out.ctrl) : '0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage (load-use section follows ID_EX_LOAD_USE_STALL_EN).
module tb_id_ex_stage;
    import core_pkg::*;

    logic        clk_ip = 1'b0;
    logic        rstn_ip;
    logic        flush_ip;
    logic        in_valid_ip;
    logic        in_ready_op;
    logic [31:0] pc_ip, rs1_data_ip, rs2_data_ip, imm_ip;
    logic [4:0]  rs1_addr_ip, rs2_addr_ip, rd_addr_ip;
    logic [3:0]  funct_ip;
    logic [15:0] ctrl_ip;
    logic        out_valid_op;
    logic        out_ready_ip;
    logic [31:0] pc_op, rs1_data_op, rs2_data_op, imm_op;
    logic [4:0]  rs1_addr_op, rs2_addr_op, rd_addr_op;
    logic [3:0]  funct_op;
    logic [15:0] ctrl_op;

    int checks = 0;
    int errors = 0;
    id_ex_bundle_t sb_q[$];

`ifdef ID_EX_LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    always #5 clk_ip = ~clk_ip;

    id_ex_stage dut (
        .clk_ip       (clk_ip),
        .rstn_ip      (rstn_ip),
        .flush_ip     (flush_ip),
        .in_valid_ip  (in_valid_ip),
        .in_ready_op  (in_ready_op),
        .pc_ip        (pc_ip),
        .rs1_data_ip  (rs1_data_ip),
        .rs2_data_ip  (rs2_data_ip),
        .imm_ip       (imm_ip),
        .rs1_addr_ip  (rs1_addr_ip),
        .rs2_addr_ip  (rs2_addr_ip),
        .rd_addr_ip   (rd_addr_ip),
        .funct_ip     (funct_ip),
        .ctrl_ip      (ctrl_ip),
        .out_valid_op (out_valid_op),
        .out_ready_ip (out_ready_ip),
        .pc_op        (pc_op),
        .rs1_data_op  (rs1_data_op),
        .rs2_data_op  (rs2_data_op),
        .imm_op       (imm_op),
        .rs1_addr_op  (rs1_addr_op),
        .rs2_addr_op  (rs2_addr_op),
        .rd_addr_op   (rd_addr_op),
        .funct_op     (funct_op),
        .ctrl_op      (ctrl_op)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle; exp_rdy/exp_ov are the independently expected handshake states.
    task automatic step(input bit v, input logic [31:0] pc, input logic [15:0] ctrl,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input bit ordy, input bit fl, input bit exp_rdy, input bit exp_ov);
        id_ex_bundle_t b;
        in_valid_ip  = v;
        pc_ip        = pc;
        rs1_data_ip  = pc ^ 32'hA5A5_0000;
        rs2_data_ip  = ~pc;
        imm_ip       = pc + 32'h100;
        rs1_addr_ip  = rs1;
        rs2_addr_ip  = rs2;
        rd_addr_ip   = rd;
        funct_ip     = pc[5:2];
        ctrl_ip      = ctrl;
        out_ready_ip = ordy;
        flush_ip     = fl;
        @(negedge clk_ip);
        chk("in_ready", 32'(in_ready_op), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid_op), 32'(exp_ov));
        if (exp_ov) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(1), 32'(0));
            end else begin
                b = sb_q[0];
                chk("pc", pc_op, b.pc);
                chk("rs1_data", rs1_data_op, b.rs1_data);
                chk("rs2_data", rs2_data_op, b.rs2_data);
                chk("imm", imm_op, b.imm);
                chk("addrs", {17'd0, rs1_addr_op, rs2_addr_op, rd_addr_op},
                    {17'd0, b.rs1_addr, b.rs2_addr, b.rd_addr});
                chk("funct", 32'(funct_op), 32'(b.funct));
                chk("ctrl", 32'(ctrl_op), 32'(b.ctrl));
                if (ordy) void'(sb_q.pop_front());
            end
        end else begin
            chk("ctrl_bubble", 32'(ctrl_op), 32'd0);
        end
        if (fl) sb_q.delete();
        if (v && exp_rdy && !fl) begin
            b          = '0;
            b.pc       = pc;
            b.rs1_data = pc ^ 32'hA5A5_0000;
            b.rs2_data = ~pc;
            b.imm      = pc + 32'h100;
            b.rs1_addr = rs1;
            b.rs2_addr = rs2;
            b.rd_addr  = rd;
            b.funct    = pc[5:2];
            b.ctrl     = ctrl;
            sb_q.push_back(b);
        end
        @(posedge clk_ip);
        #1;
    endtask

    initial begin
        rstn_ip = 1'b0;
        flush_ip = 1'b0; in_valid_ip = 1'b0; out_ready_ip = 1'b0;
        pc_ip = '0; rs1_data_ip = '0; rs2_data_ip = '0; imm_ip = '0;
        rs1_addr_ip = '0; rs2_addr_ip = '0; rd_addr_ip = '0; funct_ip = '0; ctrl_ip = '0;
        repeat (3) @(posedge clk_ip);
        #1 rstn_ip = 1'b1;

        // Reset state
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 0);

        // Streaming, back-to-back
        step(1, 32'h0, 16'h0002, 1, 2, 3, 1, 0, 1, 0);
        step(1, 32'h4, 16'h0022, 4, 5, 6, 1, 0, 1, 1);
        step(1, 32'h8, 16'h0012, 7, 8, 9, 1, 0, 1, 1);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 1);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 0);

        // Backpressure to FULL then drain in order
        step(1, 32'h10, 16'h0002, 1, 1, 10, 0, 0, 1, 0);
        step(1, 32'h14, 16'h0006, 2, 2, 11, 0, 0, 1, 1);
        step(0, 32'h0, 16'h0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 1);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 0);

        // Flush while FULL with beat C presented
        step(1, 32'h20, 16'h0002, 1, 2, 12, 0, 0, 1, 0);
        step(1, 32'h24, 16'h0002, 1, 2, 13, 0, 0, 1, 1);
        step(1, 32'h28, 16'h0002, 1, 2, 14, 0, 1, 0, 1);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 0);
        // Flush coinciding with a fire: D completes, E dropped
        step(1, 32'h30, 16'h0002, 3, 4, 15, 1, 0, 1, 0);
        step(1, 32'h34, 16'h0002, 3, 4, 16, 1, 1, 1, 1);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 0);

        // Control passthrough then bubble
        step(1, 32'h40, 16'h0106, 5, 6, 17, 1, 0, 1, 0);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 1);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 0);

        // Load-use: rd=5 load then consumer with rs2=5
        step(1, 32'h50, 16'h000B, 1, 2, 5, 1, 0, 1, 0);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 1);
        step(1, 32'h54, 16'h0022, 3, 5, 6, 1, 0, !STALL_EN, 0);
        step(1, 32'h54, 16'h0022, 3, 5, 6, 1, 0, 1, !STALL_EN);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 1);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 0);
        // Load to x0 never stalls
        step(1, 32'h60, 16'h0008, 1, 2, 0, 1, 0, 1, 0);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 1);
        step(1, 32'h64, 16'h0002, 0, 0, 7, 1, 0, 1, 0);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 1);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 0);

        // Reset mid-operation drops held beat
        step(1, 32'h70, 16'h0002, 1, 2, 8, 0, 0, 1, 0);
        in_valid_ip = 1'b0;
        rstn_ip = 1'b0;
        @(negedge clk_ip);
        chk("rst_out_valid", 32'(out_valid_op), 32'd0);
        chk("rst_ctrl", 32'(ctrl_op), 32'd0);
        chk("rst_in_ready", 32'(in_ready_op), 32'd1);
        sb_q.delete();
        @(posedge clk_ip);
        #1 rstn_ip = 1'b1;
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 0);
        step(1, 32'h80, 16'h0002, 9, 10, 11, 1, 0, 1, 0);
        step(0, 32'h0, 16'h0, 0, 0, 0, 1, 0, 1, 1);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the RV32 core.
- Captures the decode bundle (control word from the decode control unit, operands, immediate, PC, register addresses) and presents it to the execute stage.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so backpressure does not form a combinational path from EX to ID.
- Synchronous flush for branch/jump redirects.

Parameters:
- CTRL_WIDTH, 16, width of control word; bit map is in the Behaviour section.
- XLEN, 32, data/PC width.

Ports:
- clk_ip  in  1  core clock
- rstn_ip  in  1  asynchronous active-low reset
- flush_ip  in  1  kill all held and incoming beats (redirect)
- in_valid_ip  in  1  ID beat valid
- in_ready_op  out  1  stage can accept
- pc_ip  in  XLEN  instruction PC
- rs1_data_ip, rs2_data_ip  in  XLEN  regfile read data
- imm_ip  in  XLEN  sign-extended immediate
- rs1_addr_ip, rs2_addr_ip, rd_addr_ip  in  5  register indices
- funct_ip  in  4  {funct7[5], funct3}
- ctrl_ip  in  CTRL_WIDTH  control word from decode
- out_valid_op  out  1  EX beat valid
- out_ready_ip  in  1  EX accepts
- pc_op, rs1_data_op, rs2_data_op, imm_op  out  XLEN  registered copies
- rs1_addr_op, rs2_addr_op, rd_addr_op  out  5  registered copies
- funct_op  out  4  registered copy
- ctrl_op  out  CTRL_WIDTH  registered control word, gated

Behaviour:
- Control word bit map:
  - [0] is_mem_to_reg
  - [1] reg_wr_en
  - [2] mem_we
  - [3] mem_re
  - [4] is_branch
  - [5] alusrc
  - [7:6] aluop
  - [8] is_jal
  - [15:9] zero
- Reset (async, rstn_ip low): main_valid=0, skid_valid=0, all data regs 0. Outputs: out_valid_op=0, ctrl_op=0, in_ready_op=1.
- Storage: main register (drives outputs) plus skid register. in_ready_op = !skid_valid, from a flop. No combinational path from out_ready_ip to in_ready_op.
- Accept = in_valid_ip & in_ready_op & !flush_ip. Fire = out_valid_op & out_ready_ip.
- Latency: 1 cycle in to out when empty. Throughput: 1 beat/cycle while out_ready_ip=1.
- State (main_valid, skid_valid):
  - EMPTY(0,0): accept → ONE.
  - ONE(1,0):
    - accept & fire → ONE, main reloaded.
    - accept & !fire → FULL, beat goes to skid.
    - fire & !accept → EMPTY.
  - FULL(1,1): in_ready_op=0.
    - fire → ONE, skid copied to main; in_ready_op returns to 1 the next cycle.
- Ordering is strictly FIFO. The skid entry never bypasses main.
- ctrl_op is forced to 0 whenever out_valid_op=0, so a bubble never asserts reg_wr_en or mem_we.
- flush_ip has priority over everything:
  - next cycle main_valid=skid_valid=0, in_ready_op=1.
  - A beat presented in the flush cycle is dropped.
  - A fire in the flush cycle still completes, since EX saw it this cycle.
- Reset mid-operation: immediate return to EMPTY; in-flight beats are lost.
- Data registers load only on capture. Stale data is held but masked by valid/ctrl gating.

Optional Feature:
- Macro: ID_EX_LOAD_USE_STALL_EN.
- Defined:
  - The stage tracks ld_rd (5 bits) and ld_pending (1 bit), set on a fire with ctrl[3]=1 and rd≠0, and cleared on any other fire or on flush.
  - When ld_pending and in_valid_ip and (rs1_addr_ip==ld_rd or rs2_addr_ip==ld_rd), in_ready_op is forced to 0 for that cycle, inserting one bubble.
  - This adds a combinational path from the rs*_addr_ip inputs to in_ready_op.
- Undefined: no tracking; in_ready_op is purely registered; EX forwarding or software handles the hazard.

Decomposition:
- Shared package core_pkg holds:
  - ctrl bit-index constants (CTRL_MEM_TO_REG, CTRL_REG_WR, CTRL_MEM_WE, CTRL_MEM_RE, CTRL_BRANCH, CTRL_ALUSRC, CTRL_ALUOP_LO/HI, CTRL_JAL)
  - a packed struct id_ex_bundle_t {pc, rs1_data, rs2_data, imm, rs1/rs2/rd addr, funct, ctrl}.
- One sub-module: skid_buf, a generic 2-entry valid/ready register parameterised by payload width, with a flush input.
- id_ex_stage wraps skid_buf with ctrl gating and the optional hazard logic.

Test Plan:
1. Reset release with in_valid_ip=0 → out_valid_op=0, ctrl_op=0, in_ready_op=1.
2. Streaming: three beats, PC 0x0/0x4/0x8, out_ready_ip=1 → each appears on pc_op one cycle later, back-to-back, in_ready_op stays 1.
3. Backpressure:
   - out_ready_ip=0 while beats A(0x10) and B(0x14) are sent → FULL, in_ready_op=0, pc_op=0x10 held.
   - Release → 0x10 then 0x14 fire on consecutive cycles; in_ready_op=1 one cycle after the first fire.
4. Flush in FULL with beat C presented → next cycle out_valid_op=0, ctrl_op=0; C is never output.
5. Control passthrough: ctrl_ip=0x0106 (is_jal, reg_wr_en, mem_we) → ctrl_op=0x0106 while valid, 0x0000 on the following bubble cycle.
6. With ID_EX_LOAD_USE_STALL_EN: load rd=5 fires, then next beat has rs2=5 → in_ready_op=0 for exactly one cycle, that beat emerges one cycle late. With rd=0, no stall.
